// File: rtl/display_scan_mux_pkg.sv
// Shared definitions for the 4-digit display scan multiplexer:
// segment patterns (active-low {g,f,e,d,c,b,a}), FSM state encoding and
// digit count.
package display_scan_mux_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/display_scan_mux_if.sv
// Display scan bus: scan tick and BCD value in, anode/segment drive and
// current digit index out. The slave modport is the multiplexer side.
interface display_scan_if;
  import display_scan_mux_pkg::*;

  logic                          tick;
  logic [4*NUM_DIGITS-1:0]       digits_bcd;
  logic [NUM_DIGITS-1:0]         an;
  logic [6:0]                    seg;
  logic [$clog2(NUM_DIGITS)-1:0] digit_idx;

  modport master (output tick, digits_bcd, input an, seg, digit_idx);
  modport slave  (input tick, digits_bcd, output an, seg, digit_idx);

endinterface

// File: rtl/display_scan_mux_bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment pattern.
// 0..9 decode to digits, 10..14 to a dash, 15 to blank.
module bcd_to_seg7
  import display_scan_mux_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Nibble decode; the default arm covers the dash codes.
  always_comb begin
    // NOTE: a default on every path keeps this purely combinational (no latch).
    unique case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      4'd15:   seg = SEG_BLANK;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Each scan tick advances one digit; an all-off gap of GAP_CYCLES clocks
// separates digits to suppress ghosting; the BCD value is latched into a
// shadow register only at frame boundaries so a frame never tears.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 always shown; the anode still lights for uniform brightness).
module display_scan_mux
  import display_scan_mux_pkg::*;
#(
  parameter int GAP_CYCLES = 8  // legal range 1..255
) (
  input  logic           clk,
  input  logic           rst_n,
  display_scan_if.slave  bus
);

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_t      state;
  logic [1:0]  idx;
  logic [15:0] shadow;
  logic [7:0]  gap_cnt;
  logic [3:0]  an_q;
  logic [6:0]  seg_q;

  logic [3:0]  cur_nibble;
  logic [6:0]  dec_seg;
  logic [6:0]  show_seg;
  logic        lead_zero;

  assign cur_nibble = 4'(shadow >> {idx, 2'b00});

  bcd_to_seg7 u_dec (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Digit k>0 is a leading zero when it and every higher nibble are zero.
  always_comb begin
    lead_zero = 1'b0;
    case (idx)
      2'd3:    lead_zero = (shadow[15:12] == 4'h0);
      2'd2:    lead_zero = (shadow[15:8]  == 8'h00);
      2'd1:    lead_zero = (shadow[15:4]  == 12'h000);
      default: lead_zero = 1'b0;
    endcase
  end
`else
  assign lead_zero = 1'b0;
`endif

  assign show_seg = lead_zero ? SEG_BLANK : dec_seg;

  // Scan FSM; an/seg are registered from the state held during this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= 2'd0;
      shadow  <= 16'h0000;
      gap_cnt <= 8'd0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state)
        IDLE: begin
          an_q  <= AN_OFF;
          seg_q <= SEG_BLANK;
          if (bus.tick) begin
            shadow <= bus.digits_bcd;
            idx    <= 2'd0;
            state  <= SHOW;
          end
        end
        SHOW: begin
          an_q  <= ~(4'b0001 << idx);
          seg_q <= show_seg;
          if (bus.tick) begin
            gap_cnt <= GAP_LOAD;
            state   <= GAP;
          end
        end
        GAP: begin
          an_q  <= AN_OFF;
          seg_q <= SEG_BLANK;
          // Ticks arriving here are dropped, not queued.
          if (gap_cnt == 8'd0) begin
            idx   <= idx + 2'd1;
            state <= SHOW;
            if (idx == 2'd3) shadow <= bus.digits_bcd;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.digit_idx = idx;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed self-checking bench for display_scan_mux (GAP_CYCLES = 8).
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_display_scan_mux;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  display_scan_if bus ();

  display_scan_mux #(.GAP_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed patterns for 16'h1234, digit 0..3 = "4","3","2","1".
  logic [3:0] exp_an  [4];
  logic [6:0] exp_seg [4];

  task automatic do_reset();
    rst_n = 1'b0;
    bus.tick = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic tick_pulse();
    @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
  endtask

  // Tick out of SHOW, then observe the 8 gap cycles and the next digit.
  task automatic advance(output int off_cnt);
    tick_pulse();
    off_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.an == 4'b1111 && bus.seg == 7'b1111111) off_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111 || bus.digit_idx !== 2'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_idle: %0d bad cycles, required 0 (an=%b seg=%b idx=%0d)",
               bad, bus.an, bus.seg, bus.digit_idx);
    end
  endtask

  task automatic test_scan();
    int off;
    int j;
    do_reset();
    bus.digits_bcd = 16'h1234;
    tick_pulse();
    @(negedge clk);
    checks++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'b0011001 || bus.digit_idx !== 2'd0) begin
      failures++;
      $display("FAIL scan_first: an=%b seg=%b idx=%0d required 1110 0011001 0",
               bus.an, bus.seg, bus.digit_idx);
    end
    for (int d = 1; d <= 4; d++) begin
      repeat (10) @(negedge clk);
      advance(off);
      j = d % 4;
      checks++;
      if (off !== 8) begin
        failures++;
        $display("FAIL scan_gap%0d: off cycles=%0d required 8", d, off);
      end
      checks++;
      if (bus.an !== exp_an[j] || bus.seg !== exp_seg[j] || bus.digit_idx !== 2'(j)) begin
        failures++;
        $display("FAIL scan_digit%0d: an=%b seg=%b idx=%0d required %b %b %0d",
                 d, bus.an, bus.seg, bus.digit_idx, exp_an[j], exp_seg[j], j);
      end
    end
  endtask

  task automatic test_frame_latch();
    int off;
    do_reset();
    bus.digits_bcd = 16'h1234;
    tick_pulse();
    @(negedge clk);
    advance(off);
    bus.digits_bcd = 16'h5678;  // changed while digit 1 is lit
    advance(off);
    checks++;
    if (bus.an !== 4'b1011 || bus.seg !== 7'b0100100) begin
      failures++;
      $display("FAIL latch_d2: an=%b seg=%b required 1011 0100100", bus.an, bus.seg);
    end
    advance(off);
    checks++;
    if (bus.an !== 4'b0111 || bus.seg !== 7'b1111001) begin
      failures++;
      $display("FAIL latch_d3: an=%b seg=%b required 0111 1111001", bus.an, bus.seg);
    end
    advance(off);
    checks++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'b0000000 || bus.digit_idx !== 2'd0) begin
      failures++;
      $display("FAIL latch_next_frame: an=%b seg=%b idx=%0d required 1110 0000000 0",
               bus.an, bus.seg, bus.digit_idx);
    end
  endtask

  task automatic test_decode_af();
    int off;
    do_reset();
    bus.digits_bcd = 16'h00AF;
    tick_pulse();
    @(negedge clk);
    checks++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'b1111111) begin
      failures++;
      $display("FAIL decode_f: an=%b seg=%b required 1110 1111111", bus.an, bus.seg);
    end
    advance(off);
    checks++;
    if (bus.an !== 4'b1101 || bus.seg !== 7'b0111111) begin
      failures++;
      $display("FAIL decode_a: an=%b seg=%b required 1101 0111111", bus.an, bus.seg);
    end
  endtask

  task automatic test_tick_hold();
    int off;
    do_reset();
    bus.digits_bcd = 16'h1234;
    tick_pulse();
    @(negedge clk);
    // Tick high for 5 edges from SHOW, then a 1-cycle pulse inside the gap.
    @(negedge clk);
    bus.tick = 1'b1;
    off = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.an == 4'b1111 && bus.seg == 7'b1111111) off++;
      bus.tick = (k < 5) || (k == 6);
    end
    checks++;
    if (off !== 8) begin
      failures++;
      $display("FAIL hold_gap_len: off cycles=%0d required 8", off);
    end
    checks++;
    if (bus.an !== 4'b1101 || bus.seg !== 7'b0110000 || bus.digit_idx !== 2'd1) begin
      failures++;
      $display("FAIL hold_single_advance: an=%b seg=%b idx=%0d required 1101 0110000 1",
               bus.an, bus.seg, bus.digit_idx);
    end
  endtask

  task automatic test_reset_mid_gap();
    int off;
    do_reset();
    bus.digits_bcd = 16'h1234;
    tick_pulse();
    @(negedge clk);
    advance(off);
    advance(off);
    checks++;
    if (bus.digit_idx !== 2'd2) begin
      failures++;
      $display("FAIL rst_pre_idx: idx=%0d required 2", bus.digit_idx);
    end
    tick_pulse();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111 || bus.digit_idx !== 2'd0) begin
      failures++;
      $display("FAIL rst_async: an=%b seg=%b idx=%0d required 1111 1111111 0",
               bus.an, bus.seg, bus.digit_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tick_pulse();
    @(negedge clk);
    checks++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'b0011001 || bus.digit_idx !== 2'd0) begin
      failures++;
      $display("FAIL rst_restart: an=%b seg=%b idx=%0d required 1110 0011001 0",
               bus.an, bus.seg, bus.digit_idx);
    end
  endtask

  task automatic test_leading_zero();
    int off;
    logic [6:0] upper;
`ifdef LEADING_ZERO_BLANK_EN
    upper = 7'b1111111;
`else
    upper = 7'b1000000;
`endif
    do_reset();
    bus.digits_bcd = 16'h0007;
    tick_pulse();
    @(negedge clk);
    checks++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'b1111000) begin
      failures++;
      $display("FAIL lz_d0: an=%b seg=%b required 1110 1111000", bus.an, bus.seg);
    end
    for (int d = 1; d <= 3; d++) begin
      advance(off);
      checks++;
      if (bus.an !== ~(4'b0001 << d) || bus.seg !== upper) begin
        failures++;
        $display("FAIL lz_d%0d: an=%b seg=%b required %b %b",
                 d, bus.an, bus.seg, ~(4'b0001 << d), upper);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.tick = 1'b0;
    bus.digits_bcd = 16'h0000;
    exp_an[0] = 4'b1110; exp_seg[0] = 7'b0011001;
    exp_an[1] = 4'b1101; exp_seg[1] = 7'b0110000;
    exp_an[2] = 4'b1011; exp_seg[2] = 7'b0100100;
    exp_an[3] = 4'b0111; exp_seg[3] = 7'b1111001;

    test_reset();
    test_scan();
    test_frame_latch();
    test_decode_af();
    test_tick_hold();
    test_reset_mid_gap();
    test_leading_zero();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
